reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameters (name, default, meaning): RS_SIZE, 16, entry count; ROB_W, 4, ROB alias width (alias 0 = RENAMED_ZERO = operand ready); OP_W, 6, optype width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, reset; asynchronous, active-high.
- rdy, in, 1, global enable; low = pause.
- rollback_signal, in, 1, flush.
- ena_rs, in, 1, dispatch valid.
- rd_alias, in, ROB_W, destination alias.
- optype, in, OP_W, operation.
- pc, in, 32, instruction PC.
- Qi, in, ROB_W, rs1 tag; Qj, in, ROB_W, rs2 tag.
- Vi, in, 32, rs1 value; Vj, in, 32, rs2 value.
- imm, in, 32, immediate.
- alu_cdb_valid, in, 1; alu_cdb_id, in, ROB_W; alu_cdb_val, in, 32; ALU broadcast.
- lsb_cdb_valid, in, 1; lsb_cdb_id, in, ROB_W; lsb_cdb_val, in, 32; LSB broadcast.
- rs_full, out, 1, back-pressure to dispatcher.
- ena_alu, out, 1, issue valid.
- optype_2alu, out, OP_W, issued operation.
- rd_alias_2alu, out, ROB_W, issued destination alias.
- Vi_2alu, out, 32, issued rs1 value; Vj_2alu, out, 32, issued rs2 value.
- imm_2alu, out, 32, issued immediate; pc_2alu, out, 32, issued PC.

Function
REQ-003 Per entry: busy, optype, rd_alias, pc, Qi, Qj, Vi, Vj, imm.
REQ-004 On ena_rs, store the instruction into the lowest-index free entry and set busy.
REQ-005 Allocation with no free entry: request dropped; busy set unchanged; the dispatcher guarantees this never occurs.
REQ-006 rs_full is combinational and high when free entries < 2. The margin covers the dispatcher's one-cycle registered enable.
REQ-007 CDB snoop: each busy entry with Qx == cdb_id != 0 and cdb_valid high captures cdb_val into Vx and clears Qx at that edge. Both CDBs are snooped in the same cycle.
REQ-008 Allocation bypass: if the incoming Qi/Qj matches a valid CDB in the allocation cycle, store the CDB value with Q=0.
REQ-009 An entry is ready when busy && Qi==0 && Qj==0, evaluated on registered state.
REQ-010 At most one issue per cycle. The issuing entry's fields are registered onto the *_2alu outputs, ena_alu is set high, and busy is cleared at the same edge.
REQ-011 No entry ready: ena_alu is low at the next edge; the data outputs hold their previous values.
REQ-012 Latency: an instruction allocated fully ready at edge N issues at edge N+1. An entry woken by the CDB at edge N issues at edge N+1 at the earliest.
REQ-013 Simultaneous allocation and issue in one cycle are both permitted. A freed slot is reusable from the next cycle.
REQ-014 rdy low: no state change, ena_rs ignored, ena_alu low at the next edge.
REQ-015 rollback_signal high at an edge: all busy flags cleared and ena_alu low. This takes priority over allocation, snoop and issue; applies regardless of rdy.

Reset
REQ-016 While rst is high (asynchronous): all busy flags 0, ena_alu 0, all *_2alu data outputs 0, and rs_full 0 as a consequence.
REQ-017 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Configuration
REQ-018 Macro RS_ISSUE_OLDEST_EN:
- Defined: each entry keeps an allocation age stamp, and issue selects the oldest ready entry.
- Undefined: issue selects the lowest-index ready entry; no age storage is synthesized.

Structure
REQ-019 RS_SIZE, ROB_W, OP_W, RENAMED_ZERO and the optype encodings belong in the shared const.v definitions, not local to this module.
REQ-020 One sub-module, rs_select: parameterised find-first and age-based pick over RS_SIZE request bits, returning index and found flag. It is used for both free-slot and ready-entry selection.

Verification
REQ-021 Reset, then dispatch ADD rd_alias=3, Qi=0, Qj=0, Vi=5, Vj=7 -> next edge: ena_alu=1, Vi_2alu=5, Vj_2alu=7, rd_alias_2alu=3.
REQ-022 Dispatch with Qi=4, then alu_cdb_valid=1, alu_cdb_id=4, alu_cdb_val=0x10 two cycles later -> issue on the edge after the broadcast with Vi_2alu=0x10.
REQ-023 Dispatch with Qj=6 in the same cycle as lsb_cdb id=6, val=0xFF -> entry stored ready; issue next edge with Vj_2alu=0xFF.
REQ-024 Fill 15 blocked entries -> rs_full=1 after the 15th allocation (14 after); release one via CDB -> rs_full=0 once issued.
REQ-025 Hold 5 entries busy and pulse rollback_signal -> next edge: ena_alu=0, all entries free; a CDB matching an old tag causes no issue.
REQ-026 With RS_ISSUE_OLDEST_EN defined, make entries 2 then 0 ready in the same cycle (2 allocated first) -> entry 2 issues first. Without the macro, entry 0 issues first.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station slice: default sizes,
// the "operand ready" rename alias and the optype encodings.
// Optional feature macro: RS_ISSUE_OLDEST_EN (oldest-ready issue policy).
package reservation_station_pkg;

    localparam int unsigned DEF_RS_SIZE = 16;
    localparam int unsigned DEF_ROB_W   = 4;
    localparam int unsigned DEF_OP_W    = 6;

    // Alias 0 never names a ROB entry; a tag of 0 means the value is present.
    localparam int unsigned RENAMED_ZERO = 0;

    localparam logic [DEF_OP_W-1:0] OP_NOP = 6'd0;
    localparam logic [DEF_OP_W-1:0] OP_ADD = 6'd1;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 6'd2;
    localparam logic [DEF_OP_W-1:0] OP_AND = 6'd3;
    localparam logic [DEF_OP_W-1:0] OP_OR  = 6'd4;
    localparam logic [DEF_OP_W-1:0] OP_XOR = 6'd5;
    localparam logic [DEF_OP_W-1:0] OP_SLL = 6'd6;
    localparam logic [DEF_OP_W-1:0] OP_SRL = 6'd7;

endpackage

// File: rtl/reservation_station_rs_select.sv
// rs_select: picks one of N request bits.
//   USE_AGE = 0 : lowest-index set request (find-first); age input ignored.
//   USE_AGE = 1 : request with the smallest age key, ties to lowest index.
// Ports: req (request vector), age (N keys of AW bits, entry i at [i*AW +: AW]),
//        idx (selected index), found (any request set).
module rs_select #(
    parameter int unsigned N       = 16,
    parameter int unsigned IW      = 4,
    parameter int unsigned AW      = 4,
    parameter bit          USE_AGE = 1'b0
) (
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] age,
    output logic [IW-1:0]   idx,
    output logic            found
);

    generate
        if (USE_AGE) begin : g_age
            logic [AW-1:0] best;

            // Smallest key wins; strict compare keeps the lower index on ties.
            always_comb begin
                idx   = '0;
                found = 1'b0;
                best  = '0;
                for (int i = 0; i < int'(N); i++) begin
                    if (req[i] && (!found || (age[i*AW +: AW] < best))) begin
                        idx   = IW'(i);
                        best  = age[i*AW +: AW];
                        found = 1'b1;
                    end
                end
            end
        end else begin : g_first
            logic unused_age;
            assign unused_age = ^age;

            always_comb begin
                idx   = '0;
                found = 1'b0;
                for (int i = 0; i < int'(N); i++) begin
                    if (req[i] && !found) begin
                        idx   = IW'(i);
                        found = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds dispatched instructions until both source
// operands are available (snooping the ALU and LSB result buses), then
// issues one ready instruction per cycle to the ALU.
// Inputs : clk, rst (async, active-high), rdy (global enable),
//          rollback_signal (flush), dispatch (ena_rs, rd_alias, optype, pc,
//          Qi/Qj tags, Vi/Vj values, imm), ALU and LSB CDBs.
// Outputs: rs_full (combinational back-pressure), ena_alu and the *_2alu
//          issue payload (registered).
// Macro RS_ISSUE_OLDEST_EN: issue the oldest ready entry instead of the
// lowest-index one, using a per-entry age rank.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = DEF_RS_SIZE,
    parameter int unsigned ROB_W   = DEF_ROB_W,
    parameter int unsigned OP_W    = DEF_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback_signal,
    input  logic             ena_rs,
    input  logic [ROB_W-1:0] rd_alias,
    input  logic [OP_W-1:0]  optype,
    input  logic [31:0]      pc,
    input  logic [ROB_W-1:0] Qi,
    input  logic [ROB_W-1:0] Qj,
    input  logic [31:0]      Vi,
    input  logic [31:0]      Vj,
    input  logic [31:0]      imm,
    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_id,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_id,
    input  logic [31:0]      lsb_cdb_val,
    output logic             rs_full,
    output logic             ena_alu,
    output logic [OP_W-1:0]  optype_2alu,
    output logic [ROB_W-1:0] rd_alias_2alu,
    output logic [31:0]      Vi_2alu,
    output logic [31:0]      Vj_2alu,
    output logic [31:0]      imm_2alu,
    output logic [31:0]      pc_2alu
);

    localparam int unsigned IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int unsigned CW = $clog2(RS_SIZE + 1);
    localparam logic [ROB_W-1:0] Q_READY = ROB_W'(RENAMED_ZERO);
`ifdef RS_ISSUE_OLDEST_EN
    localparam bit OLDEST = 1'b1;
`else
    localparam bit OLDEST = 1'b0;
`endif

    logic [RS_SIZE-1:0] busy;
    logic [OP_W-1:0]    e_op  [RS_SIZE];
    logic [ROB_W-1:0]   e_rd  [RS_SIZE];
    logic [ROB_W-1:0]   e_qi  [RS_SIZE];
    logic [ROB_W-1:0]   e_qj  [RS_SIZE];
    logic [31:0]        e_pc  [RS_SIZE];
    logic [31:0]        e_vi  [RS_SIZE];
    logic [31:0]        e_vj  [RS_SIZE];
    logic [31:0]        e_imm [RS_SIZE];

    logic [RS_SIZE-1:0]    free_req, ready_req;
    logic [RS_SIZE*IW-1:0] age_flat;
    logic [IW-1:0]         free_idx, ready_idx;
    logic                  free_found, ready_found;
    logic [CW-1:0]         free_cnt;
    logic                  alloc_c;
    logic [ROB_W-1:0]      in_qi, in_qj;
    logic [31:0]           in_vi, in_vj;

    // Free / ready request vectors from registered state.
    always_comb begin
        free_req  = ~busy;
        ready_req = '0;
        free_cnt  = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ready_req[i] = busy[i] && (e_qi[i] == Q_READY) && (e_qj[i] == Q_READY);
            free_cnt     = free_cnt + CW'(free_req[i]);
        end
    end

    // Two free slots of margin absorb the dispatcher's registered enable.
    assign rs_full = (free_cnt < CW'(2));
    assign alloc_c = rdy && ena_rs && free_found;

    rs_select #(.N(RS_SIZE), .IW(IW), .AW(IW), .USE_AGE(1'b0)) u_free_sel (
        .req   (free_req),
        .age   ('0),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_select #(.N(RS_SIZE), .IW(IW), .AW(IW), .USE_AGE(OLDEST)) u_ready_sel (
        .req   (ready_req),
        .age   (age_flat),
        .idx   (ready_idx),
        .found (ready_found)
    );

    // Allocation-cycle bypass: an operand produced on a CDB this cycle is stored as ready.
    always_comb begin
        in_qi = Qi;
        in_vi = Vi;
        in_qj = Qj;
        in_vj = Vj;
        if (Qi != Q_READY) begin
            if (alu_cdb_valid && (alu_cdb_id == Qi)) begin
                in_qi = Q_READY;
                in_vi = alu_cdb_val;
            end else if (lsb_cdb_valid && (lsb_cdb_id == Qi)) begin
                in_qi = Q_READY;
                in_vi = lsb_cdb_val;
            end
        end
        if (Qj != Q_READY) begin
            if (alu_cdb_valid && (alu_cdb_id == Qj)) begin
                in_qj = Q_READY;
                in_vj = alu_cdb_val;
            end else if (lsb_cdb_valid && (lsb_cdb_id == Qj)) begin
                in_qj = Q_READY;
                in_vj = lsb_cdb_val;
            end
        end
    end

    // Entry storage, CDB snoop, issue and allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= '0;
            ena_alu       <= 1'b0;
            optype_2alu   <= '0;
            rd_alias_2alu <= '0;
            Vi_2alu       <= '0;
            Vj_2alu       <= '0;
            imm_2alu      <= '0;
            pc_2alu       <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                e_op[i]  <= '0;
                e_rd[i]  <= '0;
                e_qi[i]  <= '0;
                e_qj[i]  <= '0;
                e_pc[i]  <= '0;
                e_vi[i]  <= '0;
                e_vj[i]  <= '0;
                e_imm[i] <= '0;
            end
        end else if (rollback_signal) begin
            busy    <= '0;
            ena_alu <= 1'b0;
        end else if (!rdy) begin
            ena_alu <= 1'b0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (busy[i] && (e_qi[i] != Q_READY)) begin
                    if (alu_cdb_valid && (alu_cdb_id == e_qi[i])) begin
                        e_vi[i] <= alu_cdb_val;
                        e_qi[i] <= Q_READY;
                    end else if (lsb_cdb_valid && (lsb_cdb_id == e_qi[i])) begin
                        e_vi[i] <= lsb_cdb_val;
                        e_qi[i] <= Q_READY;
                    end
                end
                if (busy[i] && (e_qj[i] != Q_READY)) begin
                    if (alu_cdb_valid && (alu_cdb_id == e_qj[i])) begin
                        e_vj[i] <= alu_cdb_val;
                        e_qj[i] <= Q_READY;
                    end else if (lsb_cdb_valid && (lsb_cdb_id == e_qj[i])) begin
                        e_vj[i] <= lsb_cdb_val;
                        e_qj[i] <= Q_READY;
                    end
                end
            end

            ena_alu <= ready_found;
            if (ready_found) begin
                optype_2alu     <= e_op[ready_idx];
                rd_alias_2alu   <= e_rd[ready_idx];
                Vi_2alu         <= e_vi[ready_idx];
                Vj_2alu         <= e_vj[ready_idx];
                imm_2alu        <= e_imm[ready_idx];
                pc_2alu         <= e_pc[ready_idx];
                busy[ready_idx] <= 1'b0;
            end

            // The free slot is never the issuing slot, so both may happen together.
            if (alloc_c) begin
                busy[free_idx]  <= 1'b1;
                e_op[free_idx]  <= optype;
                e_rd[free_idx]  <= rd_alias;
                e_pc[free_idx]  <= pc;
                e_imm[free_idx] <= imm;
                e_qi[free_idx]  <= in_qi;
                e_vi[free_idx]  <= in_vi;
                e_qj[free_idx]  <= in_qj;
                e_vj[free_idx]  <= in_vj;
            end
        end
    end

`ifdef RS_ISSUE_OLDEST_EN
    // Age is a dense rank among busy entries: 0 = oldest. A new entry takes the
    // rank after all survivors; entries younger than the issued one move up.
    logic [IW-1:0] age [RS_SIZE];
    logic [CW-1:0] busy_cnt_c;
    logic [IW-1:0] new_age_c;

    assign busy_cnt_c = CW'(RS_SIZE) - free_cnt;
    assign new_age_c  = IW'(busy_cnt_c - CW'(ready_found));

    always_comb begin
        age_flat = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            age_flat[i*IW +: IW] = age[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                age[i] <= '0;
            end
        end else if (!rollback_signal && rdy) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (busy[i] && ready_found && (age[i] > age[ready_idx])) begin
                    age[i] <= age[i] - IW'(1);
                end
            end
            if (alloc_c) begin
                age[free_idx] <= new_age_c;
            end
        end
    end
`else
    assign age_flat = '0;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: a scoreboard queue holds the
// expected issue payloads in order; a negedge monitor pops and compares them.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int unsigned ROB_W = DEF_ROB_W;
    localparam int unsigned OP_W  = DEF_OP_W;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ROB_W-1:0] rd;
        logic [31:0]      vi;
        logic [31:0]      vj;
        logic [31:0]      imm;
        logic [31:0]      pc;
    } exp_t;

    logic             clk, rst, rdy, rollback_signal, ena_rs;
    logic [ROB_W-1:0] rd_alias, Qi, Qj, alu_cdb_id, lsb_cdb_id;
    logic [OP_W-1:0]  optype;
    logic [31:0]      pc, Vi, Vj, imm, alu_cdb_val, lsb_cdb_val;
    logic             alu_cdb_valid, lsb_cdb_valid;
    logic             rs_full, ena_alu;
    logic [OP_W-1:0]  optype_2alu;
    logic [ROB_W-1:0] rd_alias_2alu;
    logic [31:0]      Vi_2alu, Vj_2alu, imm_2alu, pc_2alu;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    reservation_station #(.RS_SIZE(DEF_RS_SIZE), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
        .ena_rs(ena_rs), .rd_alias(rd_alias), .optype(optype), .pc(pc),
        .Qi(Qi), .Qj(Qj), .Vi(Vi), .Vj(Vj), .imm(imm),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_id(alu_cdb_id), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_id(lsb_cdb_id), .lsb_cdb_val(lsb_cdb_val),
        .rs_full(rs_full), .ena_alu(ena_alu), .optype_2alu(optype_2alu),
        .rd_alias_2alu(rd_alias_2alu), .Vi_2alu(Vi_2alu), .Vj_2alu(Vj_2alu),
        .imm_2alu(imm_2alu), .pc_2alu(pc_2alu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rd,
                            input logic [31:0] vi, input logic [31:0] vj,
                            input logic [31:0] im, input logic [31:0] pcv);
        exp_t e;
        e.op = op; e.rd = rd; e.vi = vi; e.vj = vj; e.imm = im; e.pc = pcv;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rd,
                            input logic [ROB_W-1:0] qi, input logic [ROB_W-1:0] qj,
                            input logic [31:0] vi, input logic [31:0] vj,
                            input logic [31:0] im, input logic [31:0] pcv);
        optype = op; rd_alias = rd; Qi = qi; Qj = qj;
        Vi = vi; Vj = vj; imm = im; pc = pcv;
        ena_rs = 1'b1;
        tick(1);
        ena_rs = 1'b0;
    endtask

    task automatic cdb(input logic av, input logic [ROB_W-1:0] aid, input logic [31:0] aval,
                       input logic lv, input logic [ROB_W-1:0] lid, input logic [31:0] lval);
        alu_cdb_valid = av; alu_cdb_id = aid; alu_cdb_val = aval;
        lsb_cdb_valid = lv; lsb_cdb_id = lid; lsb_cdb_val = lval;
    endtask

    // Every issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && ena_alu) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_issue", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("issue_op",  32'(optype_2alu),   32'(mon_e.op));
                check_eq("issue_rd",  32'(rd_alias_2alu), 32'(mon_e.rd));
                check_eq("issue_vi",  Vi_2alu,  mon_e.vi);
                check_eq("issue_vj",  Vj_2alu,  mon_e.vj);
                check_eq("issue_imm", imm_2alu, mon_e.imm);
                check_eq("issue_pc",  pc_2alu,  mon_e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0; ena_rs = 1'b0;
        rd_alias = '0; optype = '0; pc = '0; Qi = '0; Qj = '0;
        Vi = '0; Vj = '0; imm = '0;
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
        tick(2);
        check_eq("rst_ena_alu", 32'(ena_alu), 32'd0);
        check_eq("rst_rs_full", 32'(rs_full), 32'd0);
        check_eq("rst_vi",      Vi_2alu, 32'd0);
        check_eq("rst_pc",      pc_2alu, 32'd0);
        rst = 1'b0;
        tick(1);

        // Ready on allocation; second dispatch allocates while the first issues.
        dispatch(OP_ADD, 4'd3, 4'd0, 4'd0, 32'd5, 32'd7, 32'd0, 32'h100);
        push_exp(OP_ADD, 4'd3, 32'd5, 32'd7, 32'd0, 32'h100);
        check_eq("ready_lat_alloc_edge", 32'(ena_alu), 32'd0);
        dispatch(OP_SUB, 4'd4, 4'd0, 4'd0, 32'd9, 32'd2, 32'd1, 32'h104);
        push_exp(OP_SUB, 4'd4, 32'd9, 32'd2, 32'd1, 32'h104);
        check_eq("ready_lat_issue_edge", 32'(ena_alu), 32'd1);
        tick(1);
        check_eq("back_to_back_issue", 32'(ena_alu), 32'd1);
        tick(1);
        check_eq("idle_after_issue", 32'(ena_alu), 32'd0);

        // Wake by ALU CDB two cycles after dispatch.
        dispatch(OP_AND, 4'd5, 4'd4, 4'd0, 32'hDEAD, 32'd2, 32'd0, 32'h200);
        tick(1);
        cdb(1'b1, 4'd4, 32'h10, 1'b0, '0, '0);
        tick(1);
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
        check_eq("wake_edge_no_issue", 32'(ena_alu), 32'd0);
        push_exp(OP_AND, 4'd5, 32'h10, 32'd2, 32'd0, 32'h200);
        tick(1);
        check_eq("wake_issue", 32'(ena_alu), 32'd1);

        // Allocation bypass from the LSB CDB.
        cdb(1'b0, '0, '0, 1'b1, 4'd6, 32'hFF);
        dispatch(OP_OR, 4'd6, 4'd0, 4'd6, 32'd3, 32'h1234, 32'd4, 32'h300);
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
        push_exp(OP_OR, 4'd6, 32'd3, 32'hFF, 32'd4, 32'h300);
        tick(1);
        check_eq("bypass_issue_vj", Vj_2alu, 32'hFF);
        tick(1);

        // rdy low: dispatch ignored, then a ready entry is held for a cycle.
        rdy = 1'b0;
        dispatch(OP_XOR, 4'd8, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0, 32'h500);
        rdy = 1'b1;
        tick(1);
        check_eq("rdy_low_drop_a", 32'(ena_alu), 32'd0);
        tick(1);
        check_eq("rdy_low_drop_b", 32'(ena_alu), 32'd0);
        dispatch(OP_SLL, 4'd9, 4'd0, 4'd0, 32'h21, 32'h22, 32'h23, 32'h504);
        rdy = 1'b0;
        tick(1);
        check_eq("rdy_low_hold", 32'(ena_alu), 32'd0);
        rdy = 1'b1;
        push_exp(OP_SLL, 4'd9, 32'h21, 32'h22, 32'h23, 32'h504);
        tick(1);
        check_eq("rdy_resume_issue", 32'(ena_alu), 32'd1);
        tick(1);

        // Fill 15 blocked entries and watch rs_full.
        for (int k = 1; k <= 15; k++) begin
            dispatch(OP_ADD, 4'(k), 4'(k), 4'd0, 32'd0, 32'(k), 32'd0, 32'h400 + 32'(4 * k));
            if (k == 14) check_eq("full_after_14", 32'(rs_full), 32'd0);
            if (k == 15) check_eq("full_after_15", 32'(rs_full), 32'd1);
        end
        cdb(1'b1, 4'd7, 32'h77, 1'b0, '0, '0);
        tick(1);
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
        check_eq("full_at_wake", 32'(rs_full), 32'd1);
        push_exp(OP_ADD, 4'd7, 32'h77, 32'd7, 32'd0, 32'h41C);
        tick(1);
        check_eq("full_after_release", 32'(rs_full), 32'd0);
        rollback_signal = 1'b1;
        tick(1);
        rollback_signal = 1'b0;
        check_eq("flush14_ena", 32'(ena_alu), 32'd0);
        check_eq("flush14_full", 32'(rs_full), 32'd0);

        // Rollback beats an entry that would issue on the same edge.
        for (int k = 1; k <= 4; k++) begin
            dispatch(OP_ADD, 4'(k), 4'(k), 4'd0, 32'd0, 32'd0, 32'd0, 32'h600);
        end
        dispatch(OP_ADD, 4'd10, 4'd0, 4'd0, 32'd1, 32'd2, 32'd0, 32'h610);
        rollback_signal = 1'b1;
        tick(1);
        rollback_signal = 1'b0;
        check_eq("rollback_ena", 32'(ena_alu), 32'd0);
        check_eq("rollback_full", 32'(rs_full), 32'd0);
        cdb(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        tick(1);
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
        check_eq("stale_tag_a", 32'(ena_alu), 32'd0);
        tick(1);
        check_eq("stale_tag_b", 32'(ena_alu), 32'd0);

        // Issue policy: slot 2 allocated before a refilled slot 0, both woken together.
        dispatch(OP_ADD, 4'd1, 4'd1, 4'd0, 32'd0, 32'hA0, 32'd0, 32'h700);
        dispatch(OP_ADD, 4'd2, 4'd2, 4'd0, 32'd0, 32'hB0, 32'd0, 32'h704);
        dispatch(OP_ADD, 4'd3, 4'd3, 4'd0, 32'd0, 32'hC0, 32'd0, 32'h708);
        cdb(1'b1, 4'd1, 32'hA1, 1'b0, '0, '0);
        tick(1);
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
        push_exp(OP_ADD, 4'd1, 32'hA1, 32'hA0, 32'd0, 32'h700);
        tick(1);
        dispatch(OP_SUB, 4'd9, 4'd5, 4'd0, 32'd0, 32'hD0, 32'd0, 32'h70C);
        cdb(1'b1, 4'd3, 32'hC3, 1'b1, 4'd5, 32'hD5);
        tick(1);
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef RS_ISSUE_OLDEST_EN
        push_exp(OP_ADD, 4'd3, 32'hC3, 32'hC0, 32'd0, 32'h708);
        push_exp(OP_SUB, 4'd9, 32'hD5, 32'hD0, 32'd0, 32'h70C);
`else
        push_exp(OP_SUB, 4'd9, 32'hD5, 32'hD0, 32'd0, 32'h70C);
        push_exp(OP_ADD, 4'd3, 32'hC3, 32'hC0, 32'd0, 32'h708);
`endif
        tick(3);
        rollback_signal = 1'b1;
        tick(1);
        rollback_signal = 1'b0;

        // Asynchronous reset mid-cycle clears everything without a clock edge.
        for (int k = 1; k <= 15; k++) begin
            dispatch(OP_OR, 4'(k), 4'(k), 4'd0, 32'd0, 32'd0, 32'd0, 32'h800);
        end
        check_eq("pre_rst_full", 32'(rs_full), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_full", 32'(rs_full), 32'd0);
        check_eq("async_rst_vi",   Vi_2alu, 32'd0);
        check_eq("async_rst_ena",  32'(ena_alu), 32'd0);
        tick(1);
        rst = 1'b0;
        cdb(1'b1, 4'd3, 32'h33, 1'b0, '0, '0);
        tick(1);
        cdb(1'b0, '0, '0, 1'b0, '0, '0);
        tick(1);
        check_eq("post_rst_no_issue", 32'(ena_alu), 32'd0);

        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
